// File: rtl/packet_assembler.sv
// Data-island packet serializer: latches one header plus four subpackets on an
// accepted start and emits them over 32 pixel clocks with their BCH parity bytes.

module packet_assembler_lane #(
  parameter int W   = 56,
  parameter int BPC = 2
) (
  input  logic           clk_pixel,
  input  logic           reset_n,
  input  logic           acc,
  input  logic           busy,
  input  logic [4:0]     cnt,
  input  logic [W-1:0]   din,
  output logic [BPC-1:0] dout
);
  localparam logic [4:0] NDATA = 5'(W / BPC);

  logic [W-1:0] sh_q;
  logic [7:0]   ecc_q, ecc_nxt;
  logic         data_phase;

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  assign data_phase = (cnt < NDATA);

  // Parity is chained through every bit of this cycle, lowest bit first.
  always_comb begin
    ecc_nxt = ecc_q;
    for (int i = 0; i < BPC; i++) ecc_nxt = ecc_step(ecc_nxt, sh_q[i]);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      ecc_q <= '0;
    end else if (acc) begin
      sh_q  <= din;
      ecc_q <= '0;
    end else if (busy) begin
      if (data_phase) begin
        sh_q  <= sh_q >> BPC;
        ecc_q <= ecc_nxt;
      end else begin
        ecc_q <= ecc_q >> BPC;
      end
    end
  end

  assign dout = !busy     ? '0 :
                data_phase ? sh_q[BPC-1:0] : ecc_q[BPC-1:0];
endmodule

module packet_assembler (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] header,
  input  logic [55:0] sub0,
  input  logic [55:0] sub1,
  input  logic [55:0] sub2,
  input  logic [55:0] sub3,
  output logic        busy,
  output logic [8:0]  packet_data,
  output logic        last
);
  localparam int NUM_LANES = 4;

  logic [4:0]                     counter_q;
  logic                           busy_q;
  logic                           acc;
  logic [NUM_LANES-1:0][55:0]     sub_in;
  logic [NUM_LANES-1:0][1:0]      sub_bits;
  logic [NUM_LANES-1:0]           sub_even, sub_odd;
  logic [0:0]                     hdr_bit;

  assign last = busy_q && (counter_q == 5'd31);
  // A start in the final cycle chains the next packet with no gap.
  assign acc  = start && (!busy_q || last);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      counter_q <= '0;
    end else if (acc) begin
      busy_q    <= 1'b1;
      counter_q <= '0;
    end else if (busy_q) begin
      counter_q <= counter_q + 5'd1;
      if (last) busy_q <= 1'b0;
    end
  end

  packet_assembler_lane #(.W(24), .BPC(1)) u_hdr (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .acc(acc), .busy(busy_q),
    .cnt(counter_q), .din(header), .dout(hdr_bit)
  );

  assign sub_in = {sub3, sub2, sub1, sub0};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_sub
    packet_assembler_lane #(.W(56), .BPC(2)) u_lane (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .acc(acc), .busy(busy_q),
      .cnt(counter_q), .din(sub_in[k]), .dout(sub_bits[k])
    );
    assign sub_even[k] = sub_bits[k][0];
    assign sub_odd[k]  = sub_bits[k][1];
  end

  assign busy        = busy_q;
  assign packet_data = {sub_odd, sub_even, hdr_bit};
endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: the driver predicts whole packets from
// the serializer/BCH rules, a monitor compares every output cycle.

module tb_packet_assembler;
  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic [23:0] header    = '0;
  logic [3:0][55:0] sd   = '0;
  logic        busy, last;
  logic [8:0]  packet_data;

  int errs = 0, checks = 0;
  int rem  = 0;
  int accepted = 0;
  logic [9:0] expq[$];

  packet_assembler dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .start(start), .header(header),
    .sub0(sd[0]), .sub1(sd[1]), .sub2(sd[2]), .sub3(sd[3]),
    .busy(busy), .packet_data(packet_data), .last(last)
  );

  initial forever #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected 32-cycle stream for one packet, each entry {last, packet_data}.
  task automatic push_packet(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0] he;
    logic [3:0][7:0] se;
    logic [8:0] w;
    he = '0;
    for (int i = 0; i < 24; i++) he = bch(he, h[i]);
    for (int k = 0; k < 4; k++) begin
      se[k] = '0;
      for (int i = 0; i < 56; i++) se[k] = bch(se[k], s[k][i]);
    end
    for (int n = 0; n < 32; n++) begin
      w = '0;
      w[0] = (n < 24) ? h[n] : he[k8(n - 24)];
      for (int k = 0; k < 4; k++) begin
        w[1+k] = (n < 28) ? s[k][2*n]   : se[k][2*(n-28)];
        w[5+k] = (n < 28) ? s[k][2*n+1] : se[k][2*(n-28)+1];
      end
      expq.push_back({(n == 31), w});
    end
  endtask

  function automatic int k8(input int v);
    return v & 7;
  endfunction

  // One clock of stimulus; acceptance is predicted from packet position alone.
  task automatic cycle(input logic s, input logic [23:0] h, input logic [3:0][55:0] sp);
    @(negedge clk_pixel);
    start = s; header = h; sd = sp;
    if (s && (rem == 0 || rem == 1)) begin
      push_packet(h, sp);
      rem = 32;
      accepted++;
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 24'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  function automatic logic [55:0] r56();
    return {24'($urandom), $urandom};
  endfunction

  // Monitor: one comparison per clock, sampled after the edge settles.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (!reset_n) continue;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("busy", {31'd0, busy}, 32'd1);
        check("data_last", {22'd0, last, packet_data}, {22'd0, e});
      end else begin
        check("idle", {22'd0, busy, last, packet_data}, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0][55:0] acr;
    logic [55:0] acr_sub;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_data", {23'd0, packet_data}, 32'd0);
    @(negedge clk_pixel);
    reset_n = 1'b1;

    // All-zero packet
    cycle(1'b1, '0, '0);
    idle(36);

    // ACR packet, identical subpackets
    acr_sub = {12'd0, 20'd30000, 4'd0, 20'd6144};
    acr = {acr_sub, acr_sub, acr_sub, acr_sub};
    cycle(1'b1, 24'h000001, acr);
    idle(36);

    // start held high: three chained packets, inputs changing every cycle
    for (int i = 0; i < 96; i++) cycle(1'b1, 24'($urandom), {r56(), r56(), r56(), r56()});
    idle(36);

    // start pulse mid-packet is ignored
    cycle(1'b1, 24'hABCDEF, {r56(), r56(), r56(), r56()});
    idle(10);
    cycle(1'b1, 24'h123456, {r56(), r56(), r56(), r56()});
    idle(30);

    // reset at packet cycle 15
    cycle(1'b1, 24'h5A5A5A, {r56(), r56(), r56(), r56()});
    idle(15);
    @(negedge clk_pixel);
    reset_n = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_out", {22'd0, last, packet_data}, 32'd0);
    expq.delete();
    rem = 0;
    @(negedge clk_pixel);
    reset_n = 1'b1;
    cycle(1'b1, 24'hC3C3C3, {r56(), r56(), r56(), r56()});
    idle(36);

    // Random traffic
    accepted = 0;
    while (accepted < 1000)
      cycle(($urandom_range(0, 3) == 0), 24'($urandom), {r56(), r56(), r56(), r56()});
    idle(36);

    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset inputs are permitted.
REQ-002 clk_pixel, input, 1: pixel clock; every register updates on its rising edge.
REQ-003 reset_n, input, 1: asynchronous, active-low reset; asserting it immediately forces every register to its reset value.
REQ-004 start, input, 1: request to begin a 32-cycle data-island packet.
REQ-005 header, input, 24: packet header (HB2..HB0); bit 0 is transmitted first.
REQ-006 sub0..sub3, input, 56 each: subpacket bodies; bit 0 of each is transmitted first.
REQ-007 busy, output, 1: high while a packet is being emitted.
REQ-008 packet_data, output, 9: per-cycle island payload.
  - bit 0: header/ECC bit.
  - bits 4:1: even bits of sub3..sub0.
  - bits 8:5: odd bits of sub3..sub0.
REQ-009 last, output, 1: high during packet cycle 31.

Function
REQ-010 A start sampled high while busy=0, or while last=1, SHALL be accepted.
  - Acceptance latches header and sub0..sub3.
  - busy=1 from the next cycle.
  - counter=0 on the next cycle.
REQ-011 A start sampled high while busy=1 and last=0 SHALL be ignored; latched data and counter are unaffected.
REQ-012 Inputs SHALL be sampled only on the accepting edge; input changes during a packet SHALL NOT affect output.
REQ-013 counter (5 bits) SHALL increment once per cycle while busy=1, running from 0 to 31.
  - At 31 with no accepted start: busy clears next cycle.
  - At 31 with an accepted start: counter returns to 0 and busy stays 1 (back-to-back, no gap cycle).
REQ-014 Packet cycle n SHALL be the cycle in which counter=n; outputs for cycle n are registered and visible in that same cycle.
REQ-015 Header channel, bit 0 of packet_data:
  - Cycles 0..23: header[n].
  - Cycles 24..31: header ECC bit (n-24), LSB first.
REQ-016 Subpacket k channel, packet_data bits {5+k, 1+k}:
  - Cycles 0..27: {sub_k[2n+1], sub_k[2n]}.
  - Cycles 28..31: ECC_k bits {2(n-28)+1, 2(n-28)}.
REQ-017 All ECC bytes SHALL use BCH with generator x^8+x^7+x^6+1, computed serially.
  - ECC resets to 0x00 when a packet is accepted.
  - Per data bit b: ecc <= (ecc>>1) ^ ((ecc[0]^b) ? 8'h83 : 8'h00).
REQ-018 Subpacket ECC SHALL apply two updates per cycle, even bit first then odd bit, through combinational chaining; no extra latency is allowed.
REQ-019 The ECC registers SHALL stop updating once all data bits are consumed: after cycle 23 for the header, after cycle 27 for subpackets.
  - From then on they are shifted out LSB first.
REQ-020 While busy=0: packet_data=9'd0 and last=0.
REQ-021 Latency SHALL be fixed: first packet bit one cycle after the accepting edge; 32 cycles per packet; zero idle cycles between back-to-back packets.

Reset
REQ-022 On reset_n low, the following SHALL be forced, asynchronously:
  - busy=0, last=0, counter=0, packet_data=0.
  - All ECC and latched-data registers = 0.
REQ-023 Reset asserted mid-packet SHALL abort the packet immediately, with no residual output after release.
REQ-024 The first start accepted after reset release SHALL produce a complete, correct packet.

Verification
REQ-025 Header and all subpackets zero, start pulse:
  - busy high for exactly 32 cycles.
  - packet_data=0 in every cycle.
  - last high in cycle 31 only.
REQ-026 header=24'h000001 (ACR), sub0..3 = {12'd0, CTS=20'd30000, 4'd0, N=20'd6144}:
  - Cycle 0 bit 0 = 1.
  - Cycles 24..31 match the bit-serial BCH reference model.
  - All four subpacket ECCs are identical.
REQ-027 start held high continuously for 3 packets:
  - busy never drops.
  - counter wraps 31->0.
  - Three distinct latched payloads are emitted.
REQ-028 start pulsed at packet cycle 10:
  - The pulse is ignored.
  - The packet completes unchanged.
  - busy=0 after cycle 31.
REQ-029 reset_n pulsed low at packet cycle 15:
  - Outputs zero asynchronously.
  - busy=0 and counter=0.
  - Next start yields a correct full packet.
REQ-030 Random header/subpacket data (1000 packets) SHALL match the software BCH/serializer scoreboard bit-exactly.
